ipsxe_floating_point_const_seq: RTL

Parametrised successor to the example-design operand-B constant ROM. It holds a 16-entry table of floating-point special and boundary constants for any EXP_WIDTH/MAN_WIDTH. It streams a selected address range over a valid/ready interface, in single-pass or loop mode, with abort. It feeds operand B of the floating-point IP example designs and testbenches.

---
 rtl/ipsxe_floating_point_const_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ipsxe_floating_point_const_seq.sv
// ============================================================================
// Module   : ipsxe_floating_point_const_seq
// Function : 16-entry floating-point constant table streamed over valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ipsxe_floating_point_const_seq #(
    parameter int EXP_WIDTH      = 8,
    parameter int MAN_WIDTH      = 23,
    parameter int PASS_CNT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            loop_mode,
    input  logic [3:0]                      first_addr,
    input  logic [3:0]                      last_addr,
    input  logic                            stop,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0]    m_data,
    output logic [3:0]                      m_index,
    output logic                            m_last,
    output logic                            busy,
    output logic                            done,
    output logic [PASS_CNT_WIDTH-1:0]       pass_cnt
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [EXP_WIDTH-1:0] c_EXP_ZERO = '0;
    localparam logic [EXP_WIDTH-1:0] c_EXP_ONE  = EXP_WIDTH'(1);
    localparam logic [EXP_WIDTH-1:0] c_EXP_ONES = '1;
    localparam logic [EXP_WIDTH-1:0] c_EXP_MAXN = c_EXP_ONES - EXP_WIDTH'(1);
    localparam logic [EXP_WIDTH-1:0] c_BIAS     = {1'b0, {(EXP_WIDTH-1){1'b1}}};
    localparam logic [EXP_WIDTH-1:0] c_BIAS_P1  = c_BIAS + EXP_WIDTH'(1);
    localparam logic [EXP_WIDTH-1:0] c_BIAS_P3  = c_BIAS + EXP_WIDTH'(3);
    localparam logic [EXP_WIDTH-1:0] c_BIAS_M1  = c_BIAS - EXP_WIDTH'(1);

    localparam logic [MAN_WIDTH-1:0] c_MAN_ZERO = '0;
    localparam logic [MAN_WIDTH-1:0] c_MAN_ONE  = MAN_WIDTH'(1);
    localparam logic [MAN_WIDTH-1:0] c_MAN_ONES = '1;
    localparam logic [MAN_WIDTH-1:0] c_MAN_QNAN = {1'b1, {(MAN_WIDTH-1){1'b0}}};

    logic [0:0]                state_q, state_d;
    logic [3:0]                addr_q, addr_d;
    logic [3:0]                first_q, first_d;
    logic [3:0]                last_q, last_d;
    logic                      loop_q, loop_d;
    logic                      stop_pend_q, stop_pend_d;
    logic                      done_q, done_d;
    logic [PASS_CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;

    logic                          w_valid;
    logic                          w_hs;
    logic                          w_at_last;
    logic                          w_end_req;
    logic [EXP_WIDTH+MAN_WIDTH:0]  w_entry;

    always_comb begin
        w_entry = '0;
        case (addr_q)
            4'd0:  w_entry = {1'b0, c_BIAS_P3,  c_MAN_ZERO};
            4'd1:  w_entry = {1'b0, c_EXP_ONES, c_MAN_ZERO};
            4'd2:  w_entry = {1'b0, c_EXP_ONES, c_MAN_QNAN};
            4'd3:  w_entry = {1'b0, c_EXP_ZERO, c_MAN_ZERO};
            4'd4:  w_entry = {1'b1, c_EXP_ZERO, c_MAN_ZERO};
            4'd5:  w_entry = {1'b0, c_BIAS,     c_MAN_ZERO};
            4'd6:  w_entry = {1'b1, c_BIAS,     c_MAN_ZERO};
            4'd7:  w_entry = {1'b0, c_EXP_ZERO, c_MAN_ONE};
            4'd8:  w_entry = {1'b0, c_EXP_ZERO, c_MAN_ONES};
            4'd9:  w_entry = {1'b0, c_EXP_ONE,  c_MAN_ZERO};
            4'd10: w_entry = {1'b0, c_EXP_MAXN, c_MAN_ONES};
            4'd11: w_entry = {1'b1, c_EXP_ONES, c_MAN_ZERO};
            4'd12: w_entry = {1'b0, c_EXP_ONES, c_MAN_ONE};
            4'd13: w_entry = {1'b0, c_BIAS_P1,  c_MAN_ZERO};
            4'd14: w_entry = {1'b0, c_BIAS_M1,  c_MAN_ZERO};
            4'd15: w_entry = {1'b1, c_BIAS_P3,  c_MAN_ZERO};
            default: w_entry = '0;
        endcase
    end

    assign w_valid   = (state_q == c_RUN);
    assign w_hs      = w_valid & m_ready;
    assign w_at_last = (addr_q == last_q);
    // A stop seen with the handshake ends on this beat; otherwise it is held
    assign w_end_req = stop | stop_pend_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        first_d     = first_q;
        last_d      = last_q;
        loop_d      = loop_q;
        stop_pend_d = stop_pend_q;
        pass_cnt_d  = pass_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d     = c_RUN;
                    addr_d      = first_addr;
                    first_d     = first_addr;
                    last_d      = last_addr;
                    loop_d      = loop_mode;
                    stop_pend_d = 1'b0;
                    pass_cnt_d  = '0;
                end
            end
            c_RUN: begin
                if (w_hs) begin
                    if (w_at_last) begin
                        pass_cnt_d = pass_cnt_q + PASS_CNT_WIDTH'(1);
                    end
                    if (w_end_req || (w_at_last && !loop_q)) begin
                        state_d     = c_IDLE;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else if (w_at_last) begin
                        addr_d = first_q;
                    end else begin
                        addr_d = addr_q + 4'd1;
                    end
                end else if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_IDLE;
            addr_q      <= 4'd0;
            first_q     <= 4'd0;
            last_q      <= 4'd0;
            loop_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            pass_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            first_q     <= first_d;
            last_q      <= last_d;
            loop_q      <= loop_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            pass_cnt_q  <= pass_cnt_d;
        end
    end

    assign m_valid  = w_valid;
    assign m_data   = w_valid ? w_entry : '0;
    assign m_index  = w_valid ? addr_q : 4'd0;
    assign m_last   = w_valid & w_at_last;
    assign busy     = w_valid;
    assign done     = done_q;
    assign pass_cnt = pass_cnt_q;

endmodule

`default_nettype wire
